alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter ALU_SIZE, default 8: operand and result width in bits, legal range 2..32.
REQ-002 Parameter SHIFT_BIT, default 1: fixed shift/rotate distance, legal range 0..ALU_SIZE-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port alu_in_a, input, ALU_SIZE bits: operand A, unsigned.
REQ-006 Port alu_in_b, input, ALU_SIZE bits: operand B, unsigned.
REQ-007 Port alu_sel, input, 4 bits: operation select.
REQ-008 Port alu_out, output, ALU_SIZE bits: registered result.
REQ-009 Port carry_out, output, 1 bit: registered carry/borrow/overflow flag.

Function
REQ-010 The module SHALL sample alu_in_a, alu_in_b and alu_sel on every rising clk edge while rst is low, and present the result on alu_out/carry_out after that edge (1-cycle latency, no handshake, new result every cycle).
REQ-011 alu_sel decode SHALL be: 0 A+B; 1 A-B; 2 A*B (low ALU_SIZE bits); 3 A/B (integer quotient); 4 A<<SHIFT_BIT; 5 A>>SHIFT_BIT (logical); 6 rotate A left by SHIFT_BIT; 7 rotate A right by SHIFT_BIT.
REQ-012 alu_sel decode SHALL continue: 8 A&B; 9 A|B; 10 A^B; 11 ~(A|B); 12 ~(A&B); 13 ~(A^B); 14 result 1 if A>B else 0; 15 result 1 if A==B else 0 (both zero-extended to ALU_SIZE).
REQ-013 carry_out SHALL be: sel 0 carry out of the ALU_SIZE+1-bit sum; sel 1 borrow (1 when A<B); sel 2 1 when any product bit above ALU_SIZE-1 is set; sel 3 1 when B==0; all other selects 0.
REQ-014 Addition and subtraction SHALL wrap modulo 2^ALU_SIZE.
REQ-015 Division by zero SHALL yield alu_out all ones with carry_out 1.
REQ-016 SHIFT_BIT 0 SHALL make sel 4..7 return A unchanged.
REQ-017 Shift left SHALL fill zeros at LSB; shift right SHALL fill zeros at MSB; rotates SHALL lose no bits.
REQ-018 The datapath SHALL be purely combinational between the input samples and the output register; no other internal state.

Reset
REQ-019 While rst is high, alu_out SHALL be 0 and carry_out SHALL be 0, asynchronously, regardless of clk.
REQ-020 On rst deassertion the first rising clk edge SHALL load a valid result from the current inputs.
REQ-021 Assertion of rst mid-stream SHALL discard the in-flight result immediately.

Configuration
REQ-022 Macro ALU_UNIT_MULDIV_EN defined: sel 2 and 3 SHALL behave per REQ-011/013/015.
REQ-023 Macro ALU_UNIT_MULDIV_EN undefined: no multiplier/divider SHALL be synthesized; sel 2 and 3 SHALL produce alu_out 0 and carry_out 0.

Verification (ALU_SIZE=8, SHIFT_BIT=1, ALU_UNIT_MULDIV_EN defined)
REQ-024 A=0x0A, B=0x02, sweep sel 0..15 one per cycle -> alu_out 0C,08,14,05,14,05,14,05,02,0A,08,F5,FD,F7,01,00; carry_out 0 throughout.
REQ-025 A=0xF6, B=0x0A, sel 0 -> alu_out 0x00, carry_out 1; sel 1 -> alu_out 0xEC, carry_out 0; sel 14 -> 0x01.
REQ-026 A=0x02, B=0x05, sel 1 -> alu_out 0xFD, carry_out 1; A=0x81, sel 6 -> 0x03; sel 7 -> 0xC0.
REQ-027 A=0x10, B=0x00, sel 3 -> alu_out 0xFF, carry_out 1; A=0x20, B=0x10, sel 2 -> alu_out 0x00, carry_out 1.
REQ-028 Drive rst high between clk edges with non-zero outputs -> alu_out 0, carry_out 0 without a clock edge; release -> result valid after next edge.
REQ-029 Rebuild with ALU_UNIT_MULDIV_EN undefined, A=0x0A, B=0x02, sel 2 and 3 -> alu_out 0x00, carry_out 0; other selects unchanged.

Source files
------------

// File: rtl/alu_unit.sv
// Registered 16-function ALU with carry/borrow/overflow flag.
// Optional multiply/divide datapath enabled by ALU_UNIT_MULDIV_EN.
module alu_unit #(
  parameter int ALU_SIZE  = 8,
  parameter int SHIFT_BIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_SIZE-1:0] alu_in_a,
  input  logic [ALU_SIZE-1:0] alu_in_b,
  input  logic [3:0]          alu_sel,
  output logic [ALU_SIZE-1:0] alu_out,
  output logic                carry_out
);

  localparam int W = ALU_SIZE;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] dbl;
  logic [W-1:0]   rotl;
  logic [W-1:0]   rotr;
  logic [W-1:0]   mul_res;
  logic           mul_cy;
  logic [W-1:0]   div_res;
  logic           div_cy;
  logic [W-1:0]   res;
  logic           cy;

  assign sum  = {1'b0, alu_in_a} + {1'b0, alu_in_b};
  assign diff = {1'b0, alu_in_a} - {1'b0, alu_in_b};

  // Rotates as windows into A concatenated with itself
  assign dbl  = {alu_in_a, alu_in_a};
  assign rotl = dbl[2*W-1-SHIFT_BIT -: W];
  assign rotr = dbl[SHIFT_BIT +: W];

`ifdef ALU_UNIT_MULDIV_EN
  logic [2*W-1:0] prod;

  assign prod    = {{W{1'b0}}, alu_in_a} * {{W{1'b0}}, alu_in_b};
  assign mul_res = prod[W-1:0];
  assign mul_cy  = |prod[2*W-1:W];
  assign div_cy  = (alu_in_b == '0);
  assign div_res = div_cy ? '1 : alu_in_a / alu_in_b;
`else
  assign mul_res = '0;
  assign mul_cy  = 1'b0;
  assign div_res = '0;
  assign div_cy  = 1'b0;
`endif

  always_comb begin
    res = '0;
    cy  = 1'b0;
    unique case (alu_sel)
      4'd0: begin
        res = sum[W-1:0];
        cy  = sum[W];
      end
      4'd1: begin
        res = diff[W-1:0];
        cy  = diff[W];
      end
      4'd2: begin
        res = mul_res;
        cy  = mul_cy;
      end
      4'd3: begin
        res = div_res;
        cy  = div_cy;
      end
      4'd4:  res = alu_in_a << SHIFT_BIT;
      4'd5:  res = alu_in_a >> SHIFT_BIT;
      4'd6:  res = rotl;
      4'd7:  res = rotr;
      4'd8:  res = alu_in_a & alu_in_b;
      4'd9:  res = alu_in_a | alu_in_b;
      4'd10: res = alu_in_a ^ alu_in_b;
      4'd11: res = ~(alu_in_a | alu_in_b);
      4'd12: res = ~(alu_in_a & alu_in_b);
      4'd13: res = ~(alu_in_a ^ alu_in_b);
      4'd14: res = {{(W-1){1'b0}}, alu_in_a > alu_in_b};
      4'd15: res = {{(W-1){1'b0}}, alu_in_a == alu_in_b};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      alu_out   <= res;
      carry_out <= cy;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit (ALU_SIZE=8, SHIFT_BIT=1).
// Expected mul/div values follow ALU_UNIT_MULDIV_EN.
module tb_alu_unit;

  typedef struct {
    logic [7:0] o;
    logic       c;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;
  logic [7:0] out;
  logic       cy;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vid    = 0;

`ifdef ALU_UNIT_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  alu_unit #(.ALU_SIZE(8), .SHIFT_BIT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_in_a (a),
    .alu_in_b (b),
    .alu_sel  (sel),
    .alu_out  (out),
    .carry_out(cy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] oa, input logic ca,
                     input logic [7:0] oe, input logic ce);
    checks++;
    if (oa !== oe || ca !== ce) begin
      errors++;
      $display("FAIL %s: out=%h carry=%b, expected out=%h carry=%b",
               nm, oa, ca, oe, ce);
    end
  endtask

  // Monitor: one result per clock edge after each issued vector
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("vec%0d", e.id), out, cy, e.o, e.c);
    end
  end

  task automatic apply(input logic [7:0] va, input logic [7:0] vb,
                       input logic [3:0] vs,
                       input logic [7:0] eo, input logic ec);
    @(negedge clk);
    a   = va;
    b   = vb;
    sel = vs;
    q.push_back('{o: eo, c: ec, id: vid});
    vid++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, expected 0", q.size());
    end
  endtask

  logic [7:0] sweep[16];

  initial begin
    sweep = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
              8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    if (!MD) begin
      sweep[2] = 8'h00;
      sweep[3] = 8'h00;
    end

    rst = 1'b1;
    a   = 8'h0A;
    b   = 8'h02;
    sel = 4'd0;
    #1;
    chk("reset_async", out, cy, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", out, cy, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 16; s++)
      apply(8'h0A, 8'h02, 4'(s), sweep[s], 1'b0);

    apply(8'hF6, 8'h0A, 4'd0,  8'h00, 1'b1);
    apply(8'hF6, 8'h0A, 4'd1,  8'hEC, 1'b0);
    apply(8'hF6, 8'h0A, 4'd14, 8'h01, 1'b0);
    apply(8'h02, 8'h05, 4'd1,  8'hFD, 1'b1);
    apply(8'h02, 8'h05, 4'd14, 8'h00, 1'b0);
    apply(8'h55, 8'h55, 4'd15, 8'h01, 1'b0);
    apply(8'h81, 8'h05, 4'd4,  8'h02, 1'b0);
    apply(8'h81, 8'h05, 4'd5,  8'h40, 1'b0);
    apply(8'h81, 8'h05, 4'd6,  8'h03, 1'b0);
    apply(8'h81, 8'h05, 4'd7,  8'hC0, 1'b0);
    apply(8'h10, 8'h00, 4'd3,  MD ? 8'hFF : 8'h00, MD);
    apply(8'h20, 8'h10, 4'd2,  8'h00, MD);
    apply(8'h64, 8'h07, 4'd3,  MD ? 8'h0E : 8'h00, 1'b0);
    apply(8'h0F, 8'h11, 4'd2,  MD ? 8'hFF : 8'h00, 1'b0);
    apply(8'hFF, 8'hFF, 4'd0,  8'hFE, 1'b1);
    apply(8'hC3, 8'h0A, 4'd10, 8'hC9, 1'b0);
    drain();

    // Output now holds the last non-zero result; reset between edges
    a   = 8'hFF;
    b   = 8'h01;
    sel = 4'd0;
    @(posedge clk);
    #1;
    chk("pre_reset", out, cy, 8'h00, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_midcycle", out, cy, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(8'h0A, 8'h02, 4'd9, 8'h0A, 1'b0);
    apply(8'h02, 8'h05, 4'd1, 8'hFD, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, expected finish");
    $fatal(1);
  end

endmodule
